fetch_sequencer: RTL and testbench

Controller for the instruction fetch stage. It drives PC_next and PC_write into the fetch block and the flush/write controls of the IF/ID register. It arbitrates between sequential fetch, jump redirect, branch redirect and hazard stall. It also implements the boot hold and the debugger's halt/step/resume sequencing, and carries fetch/cycle counters for the debug unit.

---
 rtl/fetch_sequencer.sv | 77 +++++++
 tb/tb_fetch_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage PC sequencing with boot hold, redirect arbitration,
// hazard stall and debugger halt/step/resume, plus fetch/cycle counters.
module fetch_sequencer #(
  parameter int width_B     = 32,
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_B       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [width_B-1:0] PC_actual,
  input  logic [width_B-1:0] PC_sumado,
  input  logic               stall,
  input  logic               jump,
  input  logic [width_B-1:0] jump_target,
  input  logic               branch_taken,
  input  logic [width_B-1:0] branch_target,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               resume_req,
  output logic [width_B-1:0] PC_next,
  output logic               PC_write,
  output logic               IFID_write,
  output logic               IFID_flush,
  output logic               IDEX_flush,
  output logic               halted,
  output logic [CNT_B-1:0]   fetch_count,
  output logic [CNT_B-1:0]   cycle_count
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3;
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam logic [BW-1:0] boot_last = BW'(BOOT_CYCLES - 1);
  logic [1:0] state, state_nx;
  logic [BW-1:0] boot_cnt;
  logic pending;
  logic [width_B-1:0] pend_tgt, redir_tgt;
  logic redirect, active;
  always_comb begin
    redirect   = branch_taken | jump;
    redir_tgt  = branch_taken ? branch_target : jump_target;
    active     = (state == RUN) | (state == STEP);
    PC_write   = active & (!stall | redirect | pending);
    IFID_write = (state == HALT) | PC_write;
    IFID_flush = (state == BOOT) | (state == HALT) | (active & (redirect | pending));
    IDEX_flush = active & branch_taken;
    halted     = state == HALT;
    // While halted, PC_next mirrors the current PC for the debug view; it is never written
    PC_next    = (state == BOOT) ? '0 :
                 (state == HALT) ? PC_actual :
                 redirect ? redir_tgt :
                 pending ? pend_tgt : PC_sumado;
    state_nx   = (state == BOOT) ? ((boot_cnt == boot_last) ? RUN : BOOT) :
                 (state == RUN)  ? (halt_req ? HALT : RUN) :
                 (state == HALT) ? (resume_req ? RUN : step_req ? STEP : HALT) :
                 (PC_write ? HALT : STEP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pending     <= 1'b0;
      pend_tgt    <= '0;
      fetch_count <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nx;
      boot_cnt    <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
      fetch_count <= fetch_count + CNT_B'(PC_write);
      cycle_count <= cycle_count + CNT_B'(state != BOOT);
      if ((state == HALT) && redirect) begin
        pending  <= 1'b1;
        pend_tgt <= redir_tgt;
      end else if (PC_write) begin
        pending  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven check of fetch_sequencer against a simple PC-register fetch model.
module tb_fetch_sequencer;
  logic clk, rst_n;
  logic [31:0] pc, PC_sumado, jump_target, branch_target, PC_next;
  logic stall, jump, branch_taken, halt_req, step_req, resume_req;
  logic PC_write, IFID_write, IFID_flush, IDEX_flush, halted;
  logic [31:0] fetch_count, cycle_count;
  int n_chk = 0, n_fail = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .PC_actual(pc), .PC_sumado(PC_sumado),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .PC_next(PC_next), .PC_write(PC_write), .IFID_write(IFID_write),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .halted(halted),
    .fetch_count(fetch_count), .cycle_count(cycle_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (PC_write) pc <= PC_next;
  assign PC_sumado = pc + 32'd1;

  typedef struct {
    logic s, j; logic [31:0] jt; logic b; logic [31:0] bt; logic h, st, rs;
    logic pw, iw, fl, idf, hl; logic [31:0] pcn, fc;
  } vec_t;

  function automatic vec_t mk(input logic s, j, input logic [31:0] jt, input logic b,
                              input logic [31:0] bt, input logic h, st, rs,
                              input logic pw, iw, fl, idf, hl, input logic [31:0] pcn, fc);
    vec_t v;
    v.s = s; v.j = j; v.jt = jt; v.b = b; v.bt = bt; v.h = h; v.st = st; v.rs = rs;
    v.pw = pw; v.iw = iw; v.fl = fl; v.idf = idf; v.hl = hl; v.pcn = pcn; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, j, input logic [31:0] jt, input logic b,
                       input logic [31:0] bt, input logic h, st, rs);
    stall = s; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    halt_req = h; step_req = st; resume_req = rs;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pc_write"}, 32'(PC_write), 0);
    chk({tag, " ifid_write"}, 32'(IFID_write), 0);
    chk({tag, " ifid_flush"}, 32'(IFID_flush), 1);
    chk({tag, " idex_flush"}, 32'(IDEX_flush), 0);
    chk({tag, " halted"}, 32'(halted), 0);
    chk({tag, " pc_next"}, PC_next, 0);
    chk({tag, " fetch_count"}, fetch_count, 0);
    chk({tag, " cycle_count"}, cycle_count, 0);
  endtask

  vec_t v[26];

  initial begin
    //        s  j  jt     b  bt     h  st rs  pw iw fl id hl pcn    fc
    for (int i = 0; i < 4; i++)
      v[i] = mk(0, 0, 0,     0, 0,     0, 0, 0,  0, 0, 1, 0, 0, 0,     0);
    v[4]  = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 1,     0);
    v[5]  = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 2,     1);
    v[6]  = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 3,     2);
    v[7]  = mk(1, 0, 0,     0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 4,     3);
    v[8]  = mk(1, 0, 0,     0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 4,     3);
    v[9]  = mk(1, 0, 0,     0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 4,     3);
    v[10] = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 4,     3);
    v[11] = mk(1, 1, 'h80,  1, 'h40,  0, 0, 0,  1, 1, 1, 1, 0, 'h40,  4);
    v[12] = mk(0, 1, 'h80,  0, 0,     0, 0, 0,  1, 1, 1, 0, 0, 'h80,  5);
    v[13] = mk(0, 0, 0,     0, 0,     1, 0, 0,  1, 1, 0, 0, 0, 'h81,  6);
    v[14] = mk(0, 0, 0,     0, 0,     0, 0, 0,  0, 1, 1, 0, 1, 'h81,  7);
    v[15] = mk(0, 1, 'h20,  0, 0,     0, 0, 0,  0, 1, 1, 0, 1, 'h81,  7);
    v[16] = mk(0, 0, 0,     0, 0,     0, 0, 0,  0, 1, 1, 0, 1, 'h81,  7);
    v[17] = mk(0, 0, 0,     0, 0,     0, 0, 1,  0, 1, 1, 0, 1, 'h81,  7);
    v[18] = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 1, 0, 0, 'h20,  7);
    v[19] = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 'h21,  8);
    v[20] = mk(0, 0, 0,     0, 0,     1, 0, 0,  1, 1, 0, 0, 0, 'h22,  9);
    v[21] = mk(0, 0, 0,     0, 0,     0, 1, 0,  0, 1, 1, 0, 1, 'h22,  10);
    v[22] = mk(1, 0, 0,     0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 'h23,  10);
    v[23] = mk(1, 0, 0,     0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 'h23,  10);
    v[24] = mk(0, 0, 0,     0, 0,     0, 0, 0,  1, 1, 0, 0, 0, 'h23,  10);
    v[25] = mk(0, 0, 0,     0, 0,     0, 0, 0,  0, 1, 1, 0, 1, 'h23,  11);

    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;

    for (int i = 0; i < 26; i++) begin
      drive(v[i].s, v[i].j, v[i].jt, v[i].b, v[i].bt, v[i].h, v[i].st, v[i].rs);
      #3;
      chk($sformatf("r%0d pc_write", i), 32'(PC_write), 32'(v[i].pw));
      chk($sformatf("r%0d ifid_write", i), 32'(IFID_write), 32'(v[i].iw));
      chk($sformatf("r%0d ifid_flush", i), 32'(IFID_flush), 32'(v[i].fl));
      chk($sformatf("r%0d idex_flush", i), 32'(IDEX_flush), 32'(v[i].idf));
      chk($sformatf("r%0d halted", i), 32'(halted), 32'(v[i].hl));
      chk($sformatf("r%0d pc_next", i), PC_next, v[i].pcn);
      chk($sformatf("r%0d fetch_count", i), fetch_count, v[i].fc);
      chk($sformatf("r%0d cycle_count", i), cycle_count, (i < 4) ? 0 : 32'(i - 4));
      @(posedge clk); #1;
    end

    // Latch a jump while halted, then step into STEP carrying the pending target
    drive(0, 1, 'h55, 0, 0, 0, 0, 0);
    #3 chk("halt_latch halted", 32'(halted), 1);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("step_pend pc_write", 32'(PC_write), 1);
    chk("step_pend pc_next", PC_next, 'h55);
    chk("step_pend ifid_flush", 32'(IFID_flush), 1);
    rst_n = 0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk); #1 rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("reboot%0d pc_write", k), 32'(PC_write), 0);
      chk($sformatf("reboot%0d pc_next", k), PC_next, 0);
      @(posedge clk); #1;
    end
    #3;
    chk("reboot_run pc_write", 32'(PC_write), 1);
    chk("reboot_run pc_next", PC_next, 1);
    chk("reboot_run ifid_flush", 32'(IFID_flush), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
